// File: rtl/result_uart_pkg.sv
// Shared types and constants for the result_uart logger: the serialiser
// state encoding, the ASCII bytes that make up a message and small helpers
// that turn a {sel,result} pair into those bytes.
package result_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [7:0] TAG_DICE    = 8'h44;
    localparam logic [7:0] TAG_TRAFFIC = 8'h54;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    function automatic logic [7:0] tag_byte(input logic src);
        return src ? TAG_TRAFFIC : TAG_DICE;
    endfunction

    function automatic logic [7:0] digit_byte(input logic [2:0] value);
        return ASCII_ZERO + {5'd0, value};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser for a single byte. A start request that coincides with the
// last cycle of the stop bit chains straight into the next start bit, so a
// caller can stream bytes back to back without an idle gap.
module uart_tx_byte
    import result_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] baud;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_end;

    assign bit_end = (baud == BAUD_LAST);
    assign done    = (state == STOP) && bit_end;

    // Frame sequencer: every bit is held for CLKS_PER_BIT cycles, tx is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= START;
                        shift <= data;
                        baud  <= '0;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (start) begin
                            state <= START;
                            shift <= data;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/result_uart.sv
// Logs changes of the dice/traffic mux output as two-character ASCII messages
// ("D3", "T5", ...) on an 8N1 UART line. Owns change detection, the
// pending/overwrite bookkeeping and the tag-then-digit byte sequencing.
module result_uart
    import result_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] result,
    input  logic       sel,
    input  logic       en,
    output logic       tx,
    output logic       busy,
    output logic       ovr
);

    logic [3:0] current;
    logic [3:0] last;
    logic [3:0] prev;
    logic [2:0] snap_digit;
    logic       have_last;
    logic       pend;
    logic       byte_idx;
    logic       launch;
    logic       byte_done;
    logic       start_byte;
    logic [7:0] byte_data;

    assign current = {sel, result};

    // A new message may only start from idle, and only for a value not yet sent.
    assign launch = !busy && en && (!have_last || (current != last));

    // The tag goes out from the live inputs at launch; the digit comes from the snapshot.
    assign start_byte = launch || (byte_done && !byte_idx);
    assign byte_data  = launch ? tag_byte(sel) : digit_byte(snap_digit);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (start_byte),
        .data  (byte_data),
        .tx    (tx),
        .done  (byte_done)
    );

    // Message sequencing: latch the launched value, then run tag byte and digit byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= 1'b0;
            byte_idx   <= 1'b0;
            last       <= '0;
            have_last  <= 1'b0;
            snap_digit <= '0;
        end else if (launch) begin
            busy       <= 1'b1;
            byte_idx   <= 1'b0;
            last       <= current;
            have_last  <= 1'b1;
            snap_digit <= result;
        end else if (byte_done) begin
            if (!byte_idx) begin
                byte_idx <= 1'b1;
            end else begin
                byte_idx <= 1'b0;
                busy     <= 1'b0;
            end
        end
    end

    // Input changes during a message mark a pending value; a second one loses it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
            pend <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            prev <= current;
            ovr  <= 1'b0;
            if (launch) begin
                pend <= 1'b0;
            end else if (busy && (current != prev)) begin
                pend <= 1'b1;
                ovr  <= pend;
            end
        end
    end

endmodule
